// File: rtl/min_max_if.sv
// Sample stream and per-interval result bus for the min/max tracker.
interface min_max_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
);
  logic                    valid;
  logic signed [WIDTH-1:0] sample;
  logic                    interval_done;
  logic signed [WIDTH-1:0] min_val;
  logic signed [WIDTH-1:0] max_val;
  logic                    ready;
  logic [CNT_W-1:0]        sample_cnt;

  // Sample source / result consumer side
  modport master (
    output valid, sample, interval_done,
    input  min_val, max_val, ready, sample_cnt
  );

  // Tracker side
  modport slave (
    input  valid, sample, interval_done,
    output min_val, max_val, ready, sample_cnt
  );
endinterface

// File: rtl/min_max.sv
// Streaming per-interval signed min/max tracker. Folds each valid sample into
// a running extremum pair and publishes it on the closing sample of an interval.
module min_max #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  min_max_if.slave  mm_if
);

  logic signed [WIDTH-1:0] run_min_q, run_min_d;
  logic signed [WIDTH-1:0] run_max_q, run_max_d;
  logic                    empty_q, empty_d;
  logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
  logic signed [WIDTH-1:0] min_val_q, min_val_d;
  logic signed [WIDTH-1:0] max_val_q, max_val_d;
  logic [CNT_W-1:0]        sample_cnt_q, sample_cnt_d;
  logic                    ready_q, ready_d;
  logic signed [WIDTH-1:0] fold_min, fold_max;

  // Extremes including the presented sample; an empty accumulator takes the sample as-is
  always_comb begin
    fold_min = mm_if.sample;
    fold_max = mm_if.sample;
    if (!empty_q) begin
      if (run_min_q < mm_if.sample) fold_min = run_min_q;
      if (run_max_q > mm_if.sample) fold_max = run_max_q;
    end
  end

  // Next-state: accumulate on plain samples, publish and reopen on the closing sample
  always_comb begin
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    empty_d      = empty_q;
    run_cnt_d    = run_cnt_q;
    min_val_d    = min_val_q;
    max_val_d    = max_val_q;
    sample_cnt_d = sample_cnt_q;
    ready_d      = 1'b0;
    if (mm_if.valid) begin
      if (mm_if.interval_done) begin
        min_val_d    = fold_min;
        max_val_d    = fold_max;
        sample_cnt_d = run_cnt_q + CNT_W'(1);
        ready_d      = 1'b1;
        empty_d      = 1'b1;
        run_cnt_d    = '0;
      end else begin
        run_min_d = fold_min;
        run_max_d = fold_max;
        empty_d   = 1'b0;
        run_cnt_d = run_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min_q    <= '0;
      run_max_q    <= '0;
      empty_q      <= 1'b1;
      run_cnt_q    <= '0;
      min_val_q    <= '0;
      max_val_q    <= '0;
      sample_cnt_q <= '0;
      ready_q      <= 1'b0;
    end else begin
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      empty_q      <= empty_d;
      run_cnt_q    <= run_cnt_d;
      min_val_q    <= min_val_d;
      max_val_q    <= max_val_d;
      sample_cnt_q <= sample_cnt_d;
      ready_q      <= ready_d;
    end
  end

  assign mm_if.min_val    = min_val_q;
  assign mm_if.max_val    = max_val_q;
  assign mm_if.sample_cnt = sample_cnt_q;
  assign mm_if.ready      = ready_q;

endmodule

// File: tb/tb_min_max.sv
// Scoreboard bench for min_max: closing samples push expected results,
// a monitor pops and compares on every ready pulse.
module tb_min_max;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    int mn;
    int mx;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  min_max_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) mm_if ();

  min_max #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .mm_if (mm_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Present one sample; it is consumed on the next rising edge
  task automatic send(input int s, input bit done);
    exp_t e;
    mm_if.valid         = 1'b1;
    mm_if.sample        = WIDTH'(s);
    mm_if.interval_done = done;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_close(input int mn, input int mx, input int cnt);
    exp_t e;
    e.mn = mn; e.mx = mx; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit done);
    mm_if.valid         = 1'b0;
    mm_if.interval_done = done;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every ready pulse must match the oldest pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (mm_if.ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("min_val",    longint'(mm_if.min_val), longint'(e.mn));
          chk("max_val",    longint'(mm_if.max_val), longint'(e.mx));
          chk("sample_cnt", longint'(mm_if.sample_cnt), longint'(e.cnt));
        end
      end
    end
  end

  initial begin
    int s, mn, mx, k, budget;
    rst                 = 1'b1;
    mm_if.valid         = 1'b0;
    mm_if.sample        = '0;
    mm_if.interval_done = 1'b0;
    #12;
    chk("rst_min",   longint'(mm_if.min_val), 0);
    chk("rst_max",   longint'(mm_if.max_val), 0);
    chk("rst_cnt",   longint'(mm_if.sample_cnt), 0);
    chk("rst_ready", longint'(mm_if.ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic interval
    send(5, 0); send(-3, 0); send(7, 0);
    expect_close(-3, 7, 4);
    send(2, 1);
    // Follow-up interval, no carry-over
    send(100, 0);
    expect_close(50, 100, 2);
    send(50, 1);
    // Extremes: single sample, then two-sample interval right behind
    expect_close(-32768, -32768, 1);
    send(-32768, 1);
    send(32767, 0);
    expect_close(-32768, 32767, 2);
    send(-32768, 1);

    // Idle with interval_done high: no ready, outputs held
    idle(5, 1);
    chk("hold_min", longint'(mm_if.min_val), -32768);
    chk("hold_max", longint'(mm_if.max_val), 32767);
    chk("hold_cnt", longint'(mm_if.sample_cnt), 2);
    expect_close(9, 9, 1);
    send(9, 1);
    idle(1, 0);

    // Reset mid-interval
    send(-1000, 0); send(1000, 0);
    mm_if.valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_min",   longint'(mm_if.min_val), 0);
    chk("midrst_max",   longint'(mm_if.max_val), 0);
    chk("midrst_cnt",   longint'(mm_if.sample_cnt), 0);
    chk("midrst_ready", longint'(mm_if.ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(3, 0);
    expect_close(3, 4, 2);
    send(4, 1);

    // Ten 3-sample intervals driven by an external counter
    k = 0; mn = 0; mx = 0;
    for (int i = 0; i < 30; i++) begin
      s = ((i * 37) % 101) - 50;
      if (k == 0) begin mn = s; mx = s; end
      else begin
        if (s < mn) mn = s;
        if (s > mx) mx = s;
      end
      if (k == 2) begin
        expect_close(mn, mx, 3);
        send(s, 1);
        k = 0;
      end else begin
        send(s, 0);
        k++;
      end
    end
    idle(1, 0);

    // Drain: every expected close must have produced a ready pulse
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("pending_closes", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/min_max.md
Name: min_max

Overview:
- Streaming per-interval extremum tracker for signed audio samples.
- Folds every valid sample into a running minimum and maximum.
- When the upstream interval counter flags the last sample of an interval, publishes that interval's min/max and pulses ready for one cycle.
- Sits between the audio sample source / interval counter and the statistics/filtering stage that collects per-interval results.

Parameters:
- WIDTH, 16, sample width in bits; two's-complement signed.
- CNT_W, 32, width of the per-interval sample counter output.

Ports:
- clk  input  1  system clock (100 MHz); all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  sample qualifier; sample is consumed on a rising edge where valid=1.
- sample  input  WIDTH  signed audio sample.
- interval_done  input  1  marks the current valid sample as the last of its interval; ignored when valid=0.
- min_val  output  WIDTH  signed minimum of the most recently closed interval.
- max_val  output  WIDTH  signed maximum of the most recently closed interval.
- ready  output  1  one-cycle pulse: min_val/max_val just updated.
- sample_cnt  output  CNT_W  number of samples in the most recently closed interval.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: min_val=0, max_val=0, ready=0, sample_cnt=0. Running accumulator is cleared to the empty state, running count=0.
- Internal state:
  - run_min, run_max (WIDTH, signed).
  - empty flag.
  - run_cnt (CNT_W).
- All comparisons are signed; no saturation or widening is required.
- valid=1, interval_done=0:
  - If empty: run_min=run_max=sample, empty<=0.
  - Else: run_min<=min(run_min,sample), run_max<=max(run_max,sample).
  - run_cnt increments.
- valid=1, interval_done=1 (closing sample):
  - min_val/max_val <= extremes including this sample; if empty, both equal sample.
  - sample_cnt <= run_cnt+1.
  - ready<=1.
  - Accumulator returns to empty, run_cnt<=0, so the next interval is fully independent.
- Latency: outputs and ready update on the same edge that consumes the closing sample, i.e. visible the cycle after it is presented.
- ready is high for exactly one cycle per closed interval. Back-to-back closing samples on consecutive cycles give consecutive ready pulses.
- valid=0: no state change; ready<=0; interval_done is ignored (it may stay high across idle cycles).
- min_val/max_val/sample_cnt hold their value between closes.
- Equal values: ties leave run_min/run_max unchanged in value.
- run_cnt wraps modulo 2^CNT_W; no error is flagged.
- Reset mid-interval: the partial interval is discarded and outputs return to 0. The first valid sample after reset starts a new interval.
- No backpressure: every valid sample is accepted.

Test Plan:
- Reset, then samples 5,-3,7,2 with interval_done on the 4th -> one ready pulse; min_val=-3, max_val=7, sample_cnt=4.
- Follow-up interval 100,50 (done on 50) -> min_val=50, max_val=100, sample_cnt=2; no carry-over of -3/7.
- Single-sample interval -32768 with interval_done=1 -> min_val=max_val=-32768, sample_cnt=1. Then 32767,-32768 -> min=-32768, max=32767.
- Idle gaps and interval_done=1 with valid=0 for 5 cycles -> no ready, outputs unchanged. The next valid 9 with done -> ready; min=max=9.
- Assert rst mid-interval after samples -1000,1000 -> outputs 0, ready 0. Post-reset interval 3,4 -> min=3, max=4, sample_cnt=2.
- Ten consecutive 3-sample intervals fed by an external counter -> exactly 10 ready pulses with correct per-interval values.
